// File: rtl/dac_seq_pkg.sv
// Shared types and constants for the TX DAC output sequencer.
//   dac_state_t : PTT sequencing states
//   midscale()  : offset-binary code for a zero sample of a given width
//   full_gain() : unity gain value for a given ramp resolution
package dac_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        ACTIVE,
        RAMP_DOWN
    } dac_state_t;

    function automatic int unsigned midscale(input int unsigned width);
        return 32'd1 << (width - 1);
    endfunction

    function automatic int unsigned full_gain(input int unsigned ramp_bits);
        return 32'd1 << ramp_bits;
    endfunction

endpackage

// File: rtl/dac_offset_binary.sv
// Output stage: registered slice of the scaled sample plus MSB inversion,
// turning a two's-complement value into an offset-binary DAC code.
//   clk_in       : DAC-domain clock
//   reset_n      : synchronous active-low reset (code returns to midscale)
//   sample_valid : load a new code from sample
//   force_mid    : override, load midscale (takes priority over sample_valid)
//   sample       : signed scaled sample, IN_WIDTH bits
//   code         : offset-binary DAC code, OUT_WIDTH bits
import dac_seq_pkg::*;

module dac_offset_binary #(
    parameter int IN_WIDTH  = 27,
    parameter int OUT_WIDTH = 14,
    parameter int SHIFT     = 27
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 sample_valid,
    input  logic                 force_mid,
    input  logic [IN_WIDTH-1:0]  sample,
    output logic [OUT_WIDTH-1:0] code
);

    localparam logic [OUT_WIDTH-1:0] MIDSCALE = OUT_WIDTH'(midscale(OUT_WIDTH));

    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            code <= MIDSCALE;
        end else if (force_mid) begin
            code <= MIDSCALE;
        end else if (sample_valid) begin
            code <= {~sample[SHIFT-1], sample[SHIFT-2 -: OUT_WIDTH-1]};
        end
    end

endmodule

// File: rtl/dac_tx_sequencer.sv
// TX DAC output sequencer: PTT key-up/key-down with a linear gain ramp,
// midscale hold while idle, starvation flag, offset-binary output.
//   clk_in       : DAC-domain clock
//   reset_n      : synchronous active-low reset
//   tx_enable    : PTT request (level)
//   sample_valid : DATA_IN qualifier
//   DATA_IN      : signed TX sample
//   DATA_OUT     : offset-binary DAC code, 2 cycles after its sample
//   tx_ready     : full gain reached (ACTIVE)
//   busy         : any state other than IDLE
//   underrun     : sticky starvation flag
import dac_seq_pkg::*;

module dac_tx_sequencer #(
    parameter int IN_WIDTH      = 27,
    parameter int OUT_WIDTH     = 14,
    parameter int SHIFT         = 27,
    parameter int RAMP_BITS     = 10,
    parameter int STARVE_CYCLES = 64
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 tx_enable,
    input  logic                 sample_valid,
    input  logic [IN_WIDTH-1:0]  DATA_IN,
    output logic [OUT_WIDTH-1:0] DATA_OUT,
    output logic                 tx_ready,
    output logic                 busy,
    output logic                 underrun
);

    localparam int PW = IN_WIDTH + RAMP_BITS + 2;
    localparam int CW = $clog2(STARVE_CYCLES + 1);
    localparam logic [RAMP_BITS:0] FULL     = (RAMP_BITS+1)'(full_gain(RAMP_BITS));
    localparam logic [RAMP_BITS:0] GAIN_ONE = (RAMP_BITS+1)'(1);
    localparam logic [CW-1:0]      STARVE_MAX = CW'(STARVE_CYCLES);

    dac_state_t           state;
    logic [RAMP_BITS:0]   gain;
    logic [CW-1:0]        starve_cnt;

    logic signed [PW-1:0] data_ext;
    logic signed [PW-1:0] gain_ext;
    logic signed [PW-1:0] prod;
    logic signed [PW-1:0] scaled;

    logic [IN_WIDTH-1:0]  s1_data;
    logic                 s1_valid;
    logic                 s1_idle;

    // Control FSM. Transitions on tx_enable never step the gain in the same
    // cycle; gain is clamped at FULL/0 so a reversal at either end is safe.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            state    <= IDLE;
            gain     <= '0;
            tx_ready <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    gain <= '0;
                    if (tx_enable) begin
                        state <= RAMP_UP;
                        busy  <= 1'b1;
                    end
                end
                RAMP_UP: begin
                    if (!tx_enable) begin
                        state <= RAMP_DOWN;
                    end else if (gain == FULL) begin
                        state    <= ACTIVE;
                        tx_ready <= 1'b1;
                    end else if (sample_valid) begin
                        gain <= gain + GAIN_ONE;
                        if (gain == FULL - GAIN_ONE) begin
                            state    <= ACTIVE;
                            tx_ready <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    gain <= FULL;
                    if (!tx_enable) begin
                        state    <= RAMP_DOWN;
                        tx_ready <= 1'b0;
                    end
                end
                RAMP_DOWN: begin
                    if (tx_enable) begin
                        state <= RAMP_UP;
                    end else if (gain == '0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (sample_valid) begin
                        gain <= gain - GAIN_ONE;
                        if (gain == GAIN_ONE) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    gain     <= '0;
                    tx_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Starvation watchdog: counts cycles since the last sample while keyed.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            starve_cnt <= '0;
            underrun   <= 1'b0;
        end else if (state == IDLE) begin
            starve_cnt <= '0;
            if (tx_enable) begin
                underrun <= 1'b0;
            end
        end else if (sample_valid) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + CW'(1);
            if (starve_cnt == STARVE_MAX - CW'(1)) begin
                underrun <= 1'b1;
            end
        end
    end

    // Stage 1: scale by the pre-update gain. Gain <= 1.0, so the shifted
    // product always fits back into IN_WIDTH bits.
    assign data_ext = {{(RAMP_BITS+2){DATA_IN[IN_WIDTH-1]}}, DATA_IN};
    assign gain_ext = {{(IN_WIDTH+1){1'b0}}, gain};
    assign prod     = data_ext * gain_ext;
    assign scaled   = prod >>> RAMP_BITS;

    // s1_idle travels with the sample so the midscale override lands one
    // cycle after IDLE is entered, letting the last ramp-down code through.
    always_ff @(posedge clk_in) begin
        if (!reset_n) begin
            s1_data  <= '0;
            s1_valid <= 1'b0;
            s1_idle  <= 1'b0;
        end else begin
            s1_valid <= sample_valid;
            s1_idle  <= (state == IDLE);
            if (sample_valid) begin
                s1_data <= scaled[IN_WIDTH-1:0];
            end
        end
    end

    dac_offset_binary #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_out (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .sample_valid (s1_valid),
        .force_mid    (s1_idle),
        .sample       (s1_data),
        .code         (DATA_OUT)
    );

endmodule

// File: tb/tb_dac_tx_sequencer.sv
// Bench for dac_tx_sequencer at RAMP_BITS = 2 (FULL = 4).
module tb_dac_tx_sequencer;

    localparam int IW     = 27;
    localparam int OW     = 14;
    localparam int RB     = 2;
    localparam int FULL   = 4;
    localparam int STARVE = 64;
    localparam int MID    = 'h2000;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 en = 1'b0;
    logic                 valid = 1'b0;
    logic signed [IW-1:0] data = '0;
    logic [OW-1:0]        dout;
    logic                 ready;
    logic                 busy;
    logic                 und;

    int checks = 0;
    int failures = 0;
    bit chk_on = 1'b0;

    dac_tx_sequencer #(
        .IN_WIDTH      (IW),
        .OUT_WIDTH     (OW),
        .SHIFT         (27),
        .RAMP_BITS     (RB),
        .STARVE_CYCLES (STARVE)
    ) dut (
        .clk_in       (clk),
        .reset_n      (rst_n),
        .tx_enable    (en),
        .sample_valid (valid),
        .DATA_IN      (data),
        .DATA_OUT     (dout),
        .tx_ready     (ready),
        .busy         (busy),
        .underrun     (und)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Gain walks toward FULL while keyed and toward 0 while unkeyed, one step
    // per sample; a change of direction costs one cycle with no step.
    int m_out, m_gain, m_cnt;
    bit m_busy, m_rising, m_ready, m_und;
    int p_code;
    bit p_valid, p_idle;
    bit was_busy, was_rising;

    function automatic int exp_code(input longint d, input int g);
        longint s;
        s = (d * g) >>> RB;                 // floor(d * g / FULL)
        return int'((s + (longint'(1) << 26)) >>> 13);
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy = 0; m_rising = 0; m_ready = 0; m_und = 0;
            m_gain = 0; m_cnt = 0; m_out = MID;
            p_valid = 0; p_idle = 0; p_code = MID;
        end else begin
            m_out = p_idle ? MID : (p_valid ? p_code : m_out);
            p_idle  = !m_busy;
            p_valid = valid;
            if (valid) p_code = exp_code(longint'(data), m_gain);

            if (!m_busy) m_cnt = 0;
            else if (valid) m_cnt = 0;
            else if (m_cnt < STARVE) begin
                m_cnt++;
                if (m_cnt == STARVE) m_und = 1;
            end

            was_busy = m_busy;
            was_rising = m_rising;
            if (!m_busy) begin
                if (en) begin m_busy = 1; m_rising = 1; m_und = 0; end
            end else if (en) begin
                if (!m_rising) m_rising = 1;
                else if (m_gain < FULL && valid) m_gain++;
            end else begin
                if (m_rising) m_rising = 0;
                else if (m_gain == 0) m_busy = 0;
                else if (valid) begin
                    m_gain--;
                    if (m_gain == 0) m_busy = 0;
                end
            end
            m_ready = was_busy && en && was_rising && (m_gain == FULL);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            checks++;
            if (dout !== OW'(m_out) || ready !== m_ready || busy !== m_busy || und !== m_und) begin
                failures++;
                $display("FAIL model_cmp t=%0t got out=%h rdy=%b busy=%b und=%b want out=%h rdy=%b busy=%b und=%b",
                         $time, dout, ready, busy, und, m_out[OW-1:0], m_ready, m_busy, m_und);
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Literal expectation checked against both the DUT and the model.
    task automatic lit(input string nm, input int eo, input bit er, input bit eb, input bit eu);
        checks++;
        if (dout !== OW'(eo) || ready !== er || busy !== eb || und !== eu) begin
            failures++;
            $display("FAIL %s got out=%h rdy=%b busy=%b und=%b want out=%h rdy=%b busy=%b und=%b",
                     nm, dout, ready, busy, und, eo[OW-1:0], er, eb, eu);
        end
        checks++;
        if (m_out != eo || m_ready != er || m_busy != eb || m_und != eu) begin
            failures++;
            $display("FAIL %s_model got out=%h rdy=%b busy=%b und=%b want out=%h",
                     nm, m_out[OW-1:0], m_ready, m_busy, m_und, eo[OW-1:0]);
        end
    endtask

    int up_out[7]   = '{'h2000, 'h2000, 'h2000, 'h2400, 'h2800, 'h2C00, 'h3000};
    bit up_rdy[7]   = '{0, 0, 0, 0, 1, 1, 1};
    int dn_out[7]   = '{'h3000, 'h3000, 'h3000, 'h2C00, 'h2800, 'h2400, 'h2000};
    bit dn_busy[7]  = '{1, 1, 1, 1, 0, 0, 0};
    int rv_out[8]   = '{'h2800, 'h2400, 'h2400, 'h2800, 'h2C00, 'h3000, 'h3000, 'h3000};
    bit rv_rdy[8]   = '{0, 0, 0, 1, 1, 1, 1, 1};

    int en_hold;
    int gap;

    initial begin
        // reset / idle
        rst_n = 0; en = 0; valid = 1; data = IW'($urandom);
        step();
        chk_on = 1;
        lit("reset_state", MID, 0, 0, 0);
        data = IW'($urandom);
        step();
        rst_n = 1;
        data = IW'($urandom);
        step();
        lit("idle_mid", MID, 0, 0, 0);

        // ramp up
        data = 27'sh2000000; en = 1;
        for (int i = 0; i < 7; i++) begin
            step();
            lit($sformatf("ramp_up_%0d", i), up_out[i], up_rdy[i], 1, 0);
        end
        step();
        lit("active_full", 'h3000, 1, 1, 0);

        // ramp down
        en = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            lit($sformatf("ramp_dn_%0d", i), dn_out[i], 0, dn_busy[i], 0);
        end

        // reversal at gain 2
        en = 1;
        repeat (3) step();
        en = 0;
        step(); lit("rev_a", 'h2400, 0, 1, 0);
        step(); lit("rev_b", 'h2800, 0, 1, 0);
        en = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            lit($sformatf("rev_%0d", i), rv_out[i], rv_rdy[i], 1, 0);
        end

        // full-scale extremes in ACTIVE
        data = -27'sd67108864;
        repeat (3) step();
        lit("neg_full", 'h0000, 1, 1, 0);
        data = 27'sd67108863;
        repeat (3) step();
        lit("pos_full", 'h3FFF, 1, 1, 0);

        // starvation
        valid = 0;
        repeat (STARVE - 1) step();
        lit("starve_63", 'h3FFF, 1, 1, 0);
        step();
        lit("starve_64", 'h3FFF, 1, 1, 1);
        repeat (10) step();
        lit("starve_sticky", 'h3FFF, 1, 1, 1);

        // reset in the middle of a ramp-down
        en = 0; valid = 1; data = 27'sh2000000;
        repeat (3) step();
        rst_n = 0;
        step();
        lit("reset_mid", MID, 0, 0, 0);
        rst_n = 1;

        // randomized traffic
        en_hold = 0; gap = 0;
        for (int c = 0; c < 5000; c++) begin
            if (en_hold == 0) begin
                en = 1'($urandom_range(0, 1));
                en_hold = $urandom_range(1, 24);
            end else begin
                en_hold--;
            end
            if (gap > 0) begin
                valid = 0;
                gap--;
            end else begin
                valid = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 149) == 0) gap = $urandom_range(40, 90);
            end
            data  = IW'($urandom);
            rst_n = ($urandom_range(0, 599) != 0);
            step();
        end
        rst_n = 1;
        repeat (2) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
